// File: rtl/rvfpm_commit_sched.sv
// In-order commit/retire scheduler: tracks accepted X-IF instructions in a ring
// buffer and releases results in issue order once both committed and executed.
module rvfpm_commit_sched #(
  parameter int DEPTH      = 4,
  parameter int X_ID_WIDTH = 4,
  parameter int FLEN       = 32
) (
  input  logic                       ck_i,
  input  logic                       rst_ni,
  output logic                       alloc_ready_o,
  input  logic                       issue_accept_i,
  input  logic [X_ID_WIDTH-1:0]      issue_id_i,
  input  logic [4:0]                 issue_rd_i,
  input  logic                       commit_valid_i,
  input  logic [X_ID_WIDTH-1:0]      commit_id_i,
  input  logic                       commit_kill_i,
  input  logic                       ex_valid_i,
  input  logic [X_ID_WIDTH-1:0]      ex_id_i,
  input  logic [FLEN-1:0]            ex_data_i,
  output logic                       result_valid_o,
  input  logic                       result_ready_i,
  output logic [X_ID_WIDTH-1:0]      result_id_o,
  output logic [FLEN-1:0]            result_data_o,
  output logic [4:0]                 result_rd_o,
  output logic [$clog2(DEPTH):0]     inflight_o,
  output logic                       err_id_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    ST_FREE      = 3'd0,
    ST_ISSUED    = 3'd1,
    ST_COMMITTED = 3'd2,
    ST_DONE      = 3'd3,
    ST_READY     = 3'd4,
    ST_KILLED    = 3'd5
  } ent_st_e;

  ent_st_e               st_q   [DEPTH];
  ent_st_e               st_d   [DEPTH];
  logic [X_ID_WIDTH-1:0] id_q   [DEPTH];
  logic [X_ID_WIDTH-1:0] id_d   [DEPTH];
  logic [4:0]            rd_q   [DEPTH];
  logic [4:0]            rd_d   [DEPTH];
  logic [FLEN-1:0]       data_q [DEPTH];
  logic [FLEN-1:0]       data_d [DEPTH];
  logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic [DEPTH-1:0] live_s, cm_hit_s, ex_hit_s, dup_s;
  logic             full_s, issue_ok_s, cm_new_s, retire_s, ent_err_s;
  logic             c_s, e_s;

  assign full_s         = (cnt_q == CW'(DEPTH));
  assign alloc_ready_o  = (cnt_q < CW'(DEPTH));
  assign inflight_o     = cnt_q;
  assign err_id_o       = err_q;
  assign result_valid_o = (st_q[head_q] == ST_READY);
  assign result_id_o    = result_valid_o ? id_q[head_q]   : {X_ID_WIDTH{1'b0}};
  assign result_rd_o    = result_valid_o ? rd_q[head_q]   : 5'd0;
  assign result_data_o  = result_valid_o ? data_q[head_q] : {FLEN{1'b0}};

  // Id match vectors against live (non-FREE, non-KILLED) entries
  always_comb begin
    live_s   = {DEPTH{1'b0}};
    cm_hit_s = {DEPTH{1'b0}};
    ex_hit_s = {DEPTH{1'b0}};
    dup_s    = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      live_s[i]   = (st_q[i] != ST_FREE) && (st_q[i] != ST_KILLED);
      cm_hit_s[i] = live_s[i] && (id_q[i] == commit_id_i);
      ex_hit_s[i] = live_s[i] && (id_q[i] == ex_id_i);
      dup_s[i]    = live_s[i] && (id_q[i] == issue_id_i);
    end
  end

  assign issue_ok_s = issue_accept_i && !full_s && !(|dup_s);
  // A commit for an id issued this same cycle targets the new entry.
  assign cm_new_s   = issue_ok_s && commit_valid_i && (issue_id_i == commit_id_i);
  assign retire_s   = ((st_q[head_q] == ST_READY) && result_ready_i) ||
                      (st_q[head_q] == ST_KILLED);

  // Next-state for entries, pointers, occupancy and the sticky error flag
  always_comb begin
    st_d      = st_q;
    id_d      = id_q;
    rd_d      = rd_q;
    data_d    = data_q;
    head_d    = head_q;
    tail_d    = tail_q;
    cnt_d     = cnt_q;
    ent_err_s = 1'b0;
    c_s       = 1'b0;
    e_s       = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      c_s = commit_valid_i && cm_hit_s[i];
      e_s = ex_valid_i && ex_hit_s[i];
      case (st_q[i])
        ST_ISSUED: begin
          if (c_s && commit_kill_i) begin
            st_d[i] = ST_KILLED;
          end else if (c_s && e_s) begin
            st_d[i]   = ST_READY;
            data_d[i] = ex_data_i;
          end else if (c_s) begin
            st_d[i] = ST_COMMITTED;
          end else if (e_s) begin
            st_d[i]   = ST_DONE;
            data_d[i] = ex_data_i;
          end else begin
            st_d[i] = st_q[i];
          end
        end
        ST_COMMITTED: begin
          if (e_s) begin
            st_d[i]   = ST_READY;
            data_d[i] = ex_data_i;
          end else begin
            st_d[i] = st_q[i];
          end
          ent_err_s = ent_err_s | c_s;
        end
        ST_DONE: begin
          if (c_s && commit_kill_i) begin
            st_d[i] = ST_KILLED;
          end else if (c_s) begin
            st_d[i] = ST_READY;
          end else begin
            st_d[i] = st_q[i];
          end
          ent_err_s = ent_err_s | e_s;
        end
        ST_READY: begin
          ent_err_s = ent_err_s | c_s | e_s;
        end
        default: begin
          st_d[i] = st_q[i];
        end
      endcase
    end

    if (retire_s) begin
      st_d[head_q] = ST_FREE;
      head_d       = head_q + PW'(1);
    end else begin
      head_d = head_q;
    end

    if (issue_ok_s) begin
      if (cm_new_s) begin
        st_d[tail_q] = commit_kill_i ? ST_KILLED : ST_COMMITTED;
      end else begin
        st_d[tail_q] = ST_ISSUED;
      end
      id_d[tail_q]   = issue_id_i;
      rd_d[tail_q]   = issue_rd_i;
      data_d[tail_q] = {FLEN{1'b0}};
      tail_d         = tail_q + PW'(1);
    end else begin
      tail_d = tail_q;
    end

    cnt_d = cnt_q + CW'(issue_ok_s) - CW'(retire_s);
    err_d = err_q
          | (issue_accept_i && (full_s || (|dup_s)))
          | (commit_valid_i && !(|cm_hit_s) && !cm_new_s)
          | (ex_valid_i && !(|ex_hit_s))
          | ent_err_s;
  end

  // State registers
  always_ff @(posedge ck_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        st_q[i]   <= ST_FREE;
        id_q[i]   <= {X_ID_WIDTH{1'b0}};
        rd_q[i]   <= 5'd0;
        data_q[i] <= {FLEN{1'b0}};
      end
      head_q <= {PW{1'b0}};
      tail_q <= {PW{1'b0}};
      cnt_q  <= {CW{1'b0}};
      err_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      id_q   <= id_d;
      rd_q   <= rd_d;
      data_q <= data_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_rvfpm_commit_sched.sv
// Directed self-checking bench for rvfpm_commit_sched (DEPTH=4, X_ID_WIDTH=4, FLEN=32).
module tb_rvfpm_commit_sched;

  logic        ck = 1'b0;
  logic        rst_n;
  logic        alloc_ready;
  logic        issue_accept;
  logic [3:0]  issue_id;
  logic [4:0]  issue_rd;
  logic        commit_valid;
  logic [3:0]  commit_id;
  logic        commit_kill;
  logic        ex_valid;
  logic [3:0]  ex_id;
  logic [31:0] ex_data;
  logic        result_valid;
  logic        result_ready;
  logic [3:0]  result_id;
  logic [31:0] result_data;
  logic [4:0]  result_rd;
  logic [2:0]  inflight;
  logic        err_id;

  int n_checks = 0;
  int n_fail   = 0;

  rvfpm_commit_sched #(.DEPTH(4), .X_ID_WIDTH(4), .FLEN(32)) dut (
    .ck_i(ck), .rst_ni(rst_n), .alloc_ready_o(alloc_ready),
    .issue_accept_i(issue_accept), .issue_id_i(issue_id), .issue_rd_i(issue_rd),
    .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
    .ex_valid_i(ex_valid), .ex_id_i(ex_id), .ex_data_i(ex_data),
    .result_valid_o(result_valid), .result_ready_i(result_ready),
    .result_id_o(result_id), .result_data_o(result_data), .result_rd_o(result_rd),
    .inflight_o(inflight), .err_id_o(err_id)
  );

  always #5 ck = ~ck;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    issue_accept = 1'b0; issue_id = 4'd0; issue_rd = 5'd0;
    commit_valid = 1'b0; commit_id = 4'd0; commit_kill = 1'b0;
    ex_valid = 1'b0; ex_id = 4'd0; ex_data = 32'd0;
    result_ready = 1'b0;
  endtask

  // Apply the currently driven inputs for one clock edge, then return them to idle.
  task automatic step();
    @(posedge ck);
    #1;
    clear_inputs();
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    #12;
    check("rst_alloc_ready", 64'(alloc_ready), 64'd1);
    check("rst_inflight", 64'(inflight), 64'd0);
    check("rst_result_valid", 64'(result_valid), 64'd0);
    check("rst_err", 64'(err_id), 64'd0);
    @(negedge ck);
    rst_n = 1'b1;
    @(posedge ck);
    #1;
  endtask

  task automatic issue(input logic [3:0] id, input logic [4:0] rd);
    issue_accept = 1'b1; issue_id = id; issue_rd = rd;
    step();
  endtask

  task automatic commit_ex(input logic [3:0] id, input logic [31:0] d);
    commit_valid = 1'b1; commit_id = id;
    ex_valid = 1'b1; ex_id = id; ex_data = d;
    step();
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b1;
    #2;
    do_reset();

    // Single instruction with commit and completion in the same cycle
    issue(4'd3, 5'd5);
    check("t1_inflight", 64'(inflight), 64'd1);
    check("t1_rv_early", 64'(result_valid), 64'd0);
    commit_ex(4'd3, 32'h3F80_0000);
    check("t1_rv", 64'(result_valid), 64'd1);
    check("t1_id", 64'(result_id), 64'd3);
    check("t1_rd", 64'(result_rd), 64'd5);
    check("t1_data", 64'(result_data), 64'h3F80_0000);
    result_ready = 1'b1; step();
    check("t1_inflight_end", 64'(inflight), 64'd0);
    check("t1_rv_end", 64'(result_valid), 64'd0);

    // Out-of-order completion and commit still yields issue order
    issue(4'd1, 5'd1);
    issue(4'd2, 5'd2);
    ex_valid = 1'b1; ex_id = 4'd2; ex_data = 32'h4000_0000; step();
    check("t2_rv_a", 64'(result_valid), 64'd0);
    ex_valid = 1'b1; ex_id = 4'd1; ex_data = 32'h3F80_0000; step();
    check("t2_rv_b", 64'(result_valid), 64'd0);
    commit_valid = 1'b1; commit_id = 4'd2; step();
    check("t2_rv_c", 64'(result_valid), 64'd0);
    commit_valid = 1'b1; commit_id = 4'd1; step();
    check("t2_first_id", 64'(result_id), 64'd1);
    check("t2_first_data", 64'(result_data), 64'h3F80_0000);
    result_ready = 1'b1; step();
    check("t2_second_rv", 64'(result_valid), 64'd1);
    check("t2_second_id", 64'(result_id), 64'd2);
    check("t2_second_data", 64'(result_data), 64'h4000_0000);
    result_ready = 1'b1; step();
    check("t2_inflight_end", 64'(inflight), 64'd0);

    // Killed middle entry is skipped silently
    issue(4'd1, 5'd1);
    issue(4'd2, 5'd2);
    issue(4'd3, 5'd3);
    commit_valid = 1'b1; commit_id = 4'd2; commit_kill = 1'b1; step();
    commit_ex(4'd1, 32'h0000_0011);
    check("t3_id1", 64'(result_id), 64'd1);
    commit_valid = 1'b1; commit_id = 4'd3; ex_valid = 1'b1; ex_id = 4'd3;
    ex_data = 32'h0000_0033; result_ready = 1'b1; step();
    check("t3_rv_killed_head", 64'(result_valid), 64'd0);
    check("t3_inflight_a", 64'(inflight), 64'd2);
    step();
    check("t3_id3_rv", 64'(result_valid), 64'd1);
    check("t3_id3", 64'(result_id), 64'd3);
    check("t3_inflight_b", 64'(inflight), 64'd1);
    result_ready = 1'b1; step();
    check("t3_inflight_end", 64'(inflight), 64'd0);
    check("t3_err", 64'(err_id), 64'd0);

    // Fill the buffer, overflow attempt, then retire one
    do_reset();
    for (int i = 4; i < 8; i++) issue(4'(i), 5'(i));
    check("t4_alloc_full", 64'(alloc_ready), 64'd0);
    check("t4_inflight_full", 64'(inflight), 64'd4);
    check("t4_err_before", 64'(err_id), 64'd0);
    issue(4'd8, 5'd8);
    check("t4_err_overflow", 64'(err_id), 64'd1);
    check("t4_inflight_hold", 64'(inflight), 64'd4);
    commit_ex(4'd4, 32'h0000_0044);
    check("t4_head_id", 64'(result_id), 64'd4);
    result_ready = 1'b1; step();
    check("t4_alloc_after", 64'(alloc_ready), 64'd1);
    check("t4_inflight_after", 64'(inflight), 64'd3);

    // Backpressure keeps the offered result stable; unknown ex id flags an error
    do_reset();
    issue(4'd6, 5'd7);
    commit_ex(4'd6, 32'h1234_5678);
    for (int i = 0; i < 5; i++) begin
      check("t5_hold_rv", 64'(result_valid), 64'd1);
      check("t5_hold_data", 64'(result_data), 64'h1234_5678);
      step();
    end
    check("t5_err_before", 64'(err_id), 64'd0);
    ex_valid = 1'b1; ex_id = 4'd9; ex_data = 32'hDEAD_BEEF; step();
    check("t5_err_unknown", 64'(err_id), 64'd1);
    check("t5_data_after", 64'(result_data), 64'h1234_5678);
    result_ready = 1'b1; step();
    check("t5_inflight_end", 64'(inflight), 64'd0);

    // Asynchronous reset in the middle of a cycle discards everything
    do_reset();
    issue(4'd1, 5'd1);
    issue(4'd2, 5'd2);
    issue(4'd3, 5'd3);
    commit_ex(4'd1, 32'h0000_0099);
    check("t6_rv_pre", 64'(result_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rv_async", 64'(result_valid), 64'd0);
    check("t6_data_async", 64'(result_data), 64'd0);
    check("t6_inflight_async", 64'(inflight), 64'd0);
    check("t6_alloc_async", 64'(alloc_ready), 64'd1);
    @(negedge ck);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_rv_post", 64'(result_valid), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rvfpm_commit_sched.md
Name: rvfpm_commit_sched

Overview:
- In-order commit/retire scheduler between the CORE-V-XIF issue/commit interfaces and the FPU model's result path.
- Tracks every accepted instruction by X-IF id in a circular buffer and captures the execution result when the datapath completes.
- Presents results on the XIF result interface strictly in issue order, and only after the core commits them.
- Drops killed instructions without presenting any result.

Parameters:
- DEPTH, 4, number of in-flight entries (power of two, >=2)
- X_ID_WIDTH, 4, XIF instruction id width
- FLEN, 32, result data width

Ports:
- ck  in  1  clock
- rst  in  1  asynchronous reset, active-low
- alloc_ready  out  1  buffer has a free entry; issue may be accepted
- issue_accept  in  1  instruction accepted by FPU this cycle (valid&&ready&&accept)
- issue_id  in  X_ID_WIDTH  id of accepted instruction
- issue_rd  in  5  destination register of accepted instruction
- commit_valid  in  1  XIF commit strobe
- commit_id  in  X_ID_WIDTH  id being committed/killed
- commit_kill  in  1  1 = kill, 0 = commit
- ex_valid  in  1  datapath completion strobe (no backpressure)
- ex_id  in  X_ID_WIDTH  id of completed instruction
- ex_data  in  FLEN  completed result
- result_valid  out  1  head entry result offered
- result_ready  in  1  core accepts result
- result_id  out  X_ID_WIDTH  id of offered result
- result_data  out  FLEN  offered data
- result_rd  out  5  offered destination register
- inflight  out  $clog2(DEPTH)+1  number of occupied entries
- err_id  out  1  sticky protocol error flag

Behaviour:
- Reset (rst=0, async): all entries FREE, head=tail=0, inflight=0, alloc_ready=1, result_valid=0, result_id/data/rd=0, err_id=0. Reset mid-operation discards all entries with no result emitted.
- Per-entry state: FREE, ISSUED, COMMITTED, DONE, READY, KILLED. Fields: id, rd, data.
- Transitions:
  - FREE->ISSUED on issue_accept (written at tail; tail++).
  - ISSUED->COMMITTED on commit (kill=0, id match).
  - ISSUED->DONE on ex_valid (id match; data captured).
  - COMMITTED->READY on ex; DONE->READY on commit.
  - ISSUED or DONE -> KILLED on kill.
- Retire:
  - Head READY and result_valid&&result_ready -> FREE, head++.
  - Head KILLED -> FREE, head++ automatically (one entry per cycle, no result).
- Outputs:
  - result_valid=1 iff head entry is READY.
  - result_id/data/rd driven from head entry registers, zero when not valid.
  - Combinational from state registers: an ex or commit in cycle N makes result_valid visible in cycle N+1.
  - Once result_valid is asserted, the offered value holds stable until accepted.
- alloc_ready = (inflight < DEPTH), from registered count. When full, alloc_ready=0 even if a retire occurs that cycle.
- inflight: +1 on issue, -1 on retire/kill-free. Simultaneous issue and free leaves inflight unchanged.
- Id matching compares only non-FREE, non-KILLED entries; ids are unique among live entries.
- Simultaneous events:
  - issue and commit same cycle, same id: commit applies to the new entry (enters COMMITTED).
  - commit and ex same cycle, same id: entry goes directly to READY.
  - kill and ex same cycle, same id: KILLED wins, data ignored.
- Errors, each sets err_id; err_id clears only on reset:
  - issue_accept while full: ignored.
  - issue_id equal to a live entry: ignored.
  - commit/kill of an unknown id, or commit of an already committed entry: no state change.
  - ex_id unknown, or ex on an entry already DONE/READY: no state change.
- Pointer wrap: head/tail modulo DEPTH. Full and empty are distinguished by inflight, not by pointer equality.

Test Plan:
- Reset, then issue id 3 rd 5, commit 3, ex id 3 data 0x3F800000 same cycle -> next cycle result_valid=1, id=3, rd=5, data=0x3F800000; after ready, inflight=0.
- Issue ids 1,2; ex 2 (0x40000000) then ex 1 (0x3F800000); commit 2 then 1 -> results emitted order id1 then id2, nothing before id1 commits.
- Issue ids 1,2,3; kill 2; complete and commit 1,3 -> only ids 1,3 emitted; inflight returns to 0; err_id=0.
- Fill DEPTH=4 entries -> alloc_ready=0; 5th issue_accept sets err_id=1, inflight stays 4; retire one -> alloc_ready=1 next cycle.
- Hold result_ready=0 for 5 cycles with head READY -> result_valid/data stable throughout; ex on unknown id 9 -> err_id=1.
- Drive 3 entries in flight, assert rst low mid-cycle -> outputs zero immediately, alloc_ready=1, no result after release.
